flash_read_responder: RTL and testbench
=======================================

# flash_read_responder

Avalon-MM read slave for the audio path: the responder end of the word-read handshake issued by the flash read master. It accepts single-word read requests, stalls the master with `waitRequest` for a programmable access time, fetches the word from a synchronous-read sample memory and returns it with a one-cycle `readDataValid` pulse. It sits between the audio flash read master and on-chip sample storage, and also serves as the synthesizable flash stand-in for bench and board bring-up.

## Interface
Parameters:
- `ADDR_W`, 23: word-address width.
- `MEM_WORDS`, 2**20: number of populated words; addresses at or above this are out of range.
- `WAIT_CYCLES`, 4: `ACCESS` cycles per read, minimum 1.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  reset; asynchronous, active-low.
- `address`  in  ADDR_W  word address of the request.
- `read`  in  1  read request.
- `byteEnable`  in  4  byte lanes requested.
- `waitRequest`  out  1  stall; a request is accepted only when `read && !waitRequest`.
- `readData`  out  32  returned word (registered).
- `readDataValid`  out  1  one-cycle pulse; `readData` is valid this cycle.
- `addrError`  out  1  pulses with `readDataValid` when the request was out of range.
- `memAddress`  out  ADDR_W  backing memory address.
- `memRead`  out  1  backing memory read strobe.
- `memData`  in  32  backing memory data, valid the cycle after `memRead`.

## Operation
- States:
  - `IDLE`: `waitRequest`=0. On `read`: latch `address` and `byteEnable`, set the range flag (`address >= MEM_WORDS`), go to `ACCESS`.
  - `ACCESS`: `waitRequest`=1. Down-counter loaded with WAIT_CYCLES-1. When it reaches 0: `memRead`=1 (suppressed if out of range), `memAddress` = latched address, go to `CAPTURE`.
  - `CAPTURE`: `waitRequest`=1. `readData` loads `memData` (masked, see Configuration), or 0 if out of range. Go to `RESPOND`.
  - `RESPOND`: `readDataValid`=1, `addrError` = range flag, `waitRequest`=0. A new `read` is accepted here exactly as in `IDLE` (go to `ACCESS`); otherwise go to `IDLE`.
- `readData` holds its value between responses; it changes only in `CAPTURE`.
- `read` asserted while `waitRequest`=1 is ignored, with no queueing. The master must hold `read` until accepted.
- `read` dropped during `ACCESS` or `CAPTURE` does not cancel the transaction; the response is still issued.
- `memAddress` holds the latched address from accept until the next accept; it is 0 after reset.
- Every accepted request produces exactly one `readDataValid`. Responses are returned in order, with at most one outstanding.

## Timing
- Reset asserted: state `IDLE`. `readData`=0, `readDataValid`=0, `addrError`=0, `memRead`=0, `memAddress`=0.
- `waitRequest` = 1 while `reset` is low (combinational), so no request is accepted during reset.
- Reset mid-transaction: the transaction is aborted and no `readDataValid` is issued.
- Accept in cycle T:
  - `ACCESS` covers T+1 to T+W, with `memRead` high in T+W.
  - `CAPTURE` is T+W+1.
  - `readDataValid` is high in T+W+2.
- Accept-to-valid latency is WAIT_CYCLES+2.
- Back-to-back: an accept in the `RESPOND` cycle gives a request period of WAIT_CYCLES+2 cycles.

## Configuration
- `FLASH_RESPONDER_BYTE_MASK_EN` defined: in `CAPTURE`, each byte lane `i` of `readData` is zeroed when `byteEnable[i]`=0.
- Not defined: `byteEnable` is latched but ignored, and the full 32-bit word is returned.

## Structure
- Shared package `audio_flash_pkg` holds:
  - the state enum `resp_state_t` (`IDLE`, `ACCESS`, `CAPTURE`, `RESPOND`);
  - `DATA_W`=32 and `BE_W`=4;
  - the default `WAIT_CYCLES` constant.
- Sub-module `access_timer`: loadable down-counter with a `zero` flag. Width is $clog2(WAIT_CYCLES)+1.

## Test plan
- Reset low for 3 cycles, then release → all outputs 0 during reset except `waitRequest`=1; after release, `waitRequest`=0 in `IDLE`.
- WAIT_CYCLES=4, single-cycle `read` at address 0x10, memory word 0xA1B2C3D4 → `memRead` high exactly 4 cycles after accept with `memAddress`=0x10; `readDataValid` high 6 cycles after accept with `readData`=0xA1B2C3D4, pulsed for one cycle.
- `read` held continuously over addresses 0, 1, 2 → three responses spaced 6 cycles apart, in order; requests presented while `waitRequest`=1 are not double-accepted.
- Address = MEM_WORDS → no `memRead`; `readData`=0 with `addrError`=1 on the `readDataValid` cycle.
- With the macro, `byteEnable`=4'b0101 and word 0xA1B2C3D4 → `readData`=0x00B200D4. Without the macro, the same stimulus → `readData`=0xA1B2C3D4.
- `reset` pulsed low in the `CAPTURE` cycle → no `readDataValid`; the next request after reset completes normally.

Source files
------------

// File: rtl/audio_flash_pkg.sv
// Shared types and constants for the audio flash read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audio_flash_pkg;

    localparam int DATA_W              = 32;
    localparam int BE_W                = 4;
    localparam int DEFAULT_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } resp_state_t;

    function automatic logic [DATA_W-1:0] apply_byte_mask(
        input logic [DATA_W-1:0] data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] masked;
        masked = data;
        for (int i = 0; i < BE_W; i++) begin
            if (!be[i]) begin
                masked[8*i +: 8] = 8'h00;
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Latency: load takes effect next cycle; zero flag is combinational from the count.
// Backpressure: none; decrements only while i_dec is high.
module access_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM single-word read slave over a sync-read sample memory; FLASH_RESPONDER_BYTE_MASK_EN zeroes disabled byte lanes.
// Latency: accept-to-readDataValid is WAIT_CYCLES+2; one outstanding request.
// Backpressure: waitRequest high in ACCESS/CAPTURE and during reset; requests presented then are ignored.
module flash_read_responder
    import audio_flash_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int MEM_WORDS   = 2**20,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic [BE_W-1:0]   byteEnable,
    output logic              waitRequest,
    output logic [DATA_W-1:0] readData,
    output logic              readDataValid,
    output logic              addrError,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memRead,
    input  logic [DATA_W-1:0] memData
);

    localparam int                TW         = $clog2(WAIT_CYCLES) + 1;
    localparam logic [TW-1:0]     TIMER_LOAD = TW'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    resp_state_t       r_state;
    resp_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic              r_oor;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_range_err;
    logic              w_timer_zero;
    logic [DATA_W-1:0] w_capture;

    // IDLE and RESPOND are the only states that can take a new request.
    assign w_accept    = read && ((r_state == IDLE) || (r_state == RESPOND));
    assign w_range_err = ({1'b0, address} >= ADDR_LIMIT);

`ifdef FLASH_RESPONDER_BYTE_MASK_EN
    assign w_capture = apply_byte_mask(memData, r_be);
`else
    logic w_be_unused;
    assign w_be_unused = ^r_be;
    assign w_capture   = memData;
`endif

    access_timer #(
        .W(TW)
    ) u_access_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_accept),
        .i_load_val (TIMER_LOAD),
        .i_dec      (r_state == ACCESS),
        .o_zero     (w_timer_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (read) w_state_nxt = ACCESS;
            ACCESS:  if (w_timer_zero) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESPOND;
            RESPOND: w_state_nxt = read ? ACCESS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_be    <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= address;
                r_be   <= byteEnable;
                r_oor  <= w_range_err;
            end
            if (r_state == CAPTURE) begin
                r_rdata <= r_oor ? '0 : w_capture;
            end
        end
    end

    // Stall is forced during reset so nothing is accepted before the FSM is live.
    assign waitRequest   = !reset || (r_state == ACCESS) || (r_state == CAPTURE);
    assign memRead       = (r_state == ACCESS) && w_timer_zero && !r_oor;
    assign memAddress    = r_addr;
    assign readData      = r_rdata;
    assign readDataValid = (r_state == RESPOND);
    assign addrError     = (r_state == RESPOND) && r_oor;

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder with a sync-read memory model.
module tb_flash_read_responder;

    localparam int ADDR_W    = 23;
    localparam int MEM_WORDS = 2**20;
    localparam int W         = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [3:0]        byteEnable;
    logic              waitRequest;
    logic [31:0]       readData;
    logic              readDataValid;
    logic              addrError;
    logic [ADDR_W-1:0] memAddress;
    logic              memRead;
    logic [31:0]       memData = 32'h0;

    int total = 0;
    int bad   = 0;

    flash_read_responder #(
        .ADDR_W      (ADDR_W),
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_CYCLES (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .byteEnable    (byteEnable),
        .waitRequest   (waitRequest),
        .readData      (readData),
        .readDataValid (readDataValid),
        .addrError     (addrError),
        .memAddress    (memAddress),
        .memRead       (memRead),
        .memData       (memData)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 23'h10) return 32'hA1B2C3D4;
        return 32'h1000_0000 + {9'd0, a};
    endfunction

    always @(posedge clk) begin
        if (memRead) memData <= mem_word(memAddress);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-cycle request from IDLE; checks every cycle up to one past the response.
    task automatic single_req(input logic [ADDR_W-1:0] a, input logic [3:0] be,
                              input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        check("accept_ready", {31'd0, waitRequest}, 32'd0);
        read = 1'b1; address = a; byteEnable = be;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            read = 1'b0;
            check("memRead_timing", {31'd0, memRead}, {31'd0, (k == W) && !exp_e});
            check("waitReq_timing", {31'd0, waitRequest}, {31'd0, k <= W + 1});
            check("rdv_timing", {31'd0, readDataValid}, {31'd0, k == W + 2});
            if (k == W) check("memAddress", {9'd0, memAddress}, {9'd0, a});
            if (k == W + 2) begin
                check("readData", readData, exp_d);
                check("addrError", {31'd0, addrError}, {31'd0, exp_e});
            end
            if (k == W + 3) check("readData_hold", readData, exp_d);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       exp_data;
        logic              exp_err;
    } vec_t;

    vec_t vecs[6];
    int   resp_cyc[$];
    logic [31:0] resp_dat[$];

    initial begin
        vecs[0] = '{23'h10, 4'hF, 32'hA1B2C3D4, 1'b0};
`ifdef FLASH_RESPONDER_BYTE_MASK_EN
        vecs[1] = '{23'h10, 4'b0101, 32'h00B200D4, 1'b0};
        vecs[2] = '{23'h3, 4'b1000, 32'h1000_0000, 1'b0};
`else
        vecs[1] = '{23'h10, 4'b0101, 32'hA1B2C3D4, 1'b0};
        vecs[2] = '{23'h3, 4'b1000, 32'h1000_0003, 1'b0};
`endif
        vecs[3] = '{23'h100000, 4'hF, 32'h0, 1'b1};
        vecs[4] = '{23'h0FFFFF, 4'hF, 32'h100F_FFFF, 1'b0};
        vecs[5] = '{23'h7FFFFF, 4'hF, 32'h0, 1'b1};

        reset = 1'b0; read = 1'b0; address = '0; byteEnable = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_waitReq", {31'd0, waitRequest}, 32'd1);
            check("rst_outputs", {readData[31:1], readData[0] | readDataValid | addrError | memRead},
                  32'd0);
            check("rst_memAddress", {9'd0, memAddress}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("idle_waitReq", {31'd0, waitRequest}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            single_req(vecs[v].addr, vecs[v].be, vecs[v].exp_data, vecs[v].exp_err);
        end

        // read held continuously over addresses 0,1,2
        begin
            int issued = 0;
            logic acc_prev = 1'b0;
            byteEnable = 4'hF;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (readDataValid) begin
                    resp_cyc.push_back(i);
                    resp_dat.push_back(readData);
                end
                if (acc_prev) issued++;
                read = (issued < 3);
                address = ADDR_W'(issued);
                acc_prev = read && !waitRequest;
            end
            read = 1'b0;
            check("b2b_resp_count", resp_cyc.size(), 32'd3);
            for (int j = 0; j < resp_cyc.size() && j < 3; j++) begin
                check("b2b_resp_cycle", resp_cyc[j], 6 * (j + 1));
                check("b2b_resp_data", resp_dat[j], mem_word(ADDR_W'(j)));
            end
        end

        // reset pulsed in the CAPTURE cycle
        @(negedge clk);
        read = 1'b1; address = 23'h10; byteEnable = 4'hF;
        @(negedge clk);
        read = 1'b0;
        repeat (W) @(negedge clk);
        check("mid_capture_waitReq", {31'd0, waitRequest}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rdv", {31'd0, readDataValid}, 32'd0);
        check("mid_rst_waitReq", {31'd0, waitRequest}, 32'd1);
        check("mid_rst_readData", readData, 32'd0);
        check("mid_rst_memAddress", {9'd0, memAddress}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_rdv", {31'd0, readDataValid}, 32'd0);
        end
        single_req(23'h5, 4'hF, 32'h1000_0005, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
